// File: rtl/mbist_pkg.sv
// mbist_pkg: shared types and defaults for the memory-BIST sequencer.
// Holds the sequencer state enum, engine indices and timing defaults.
package mbist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISOLATE,
      ST_RST,
      ST_RUN,
      ST_CHECK,
      ST_FINISH
   } mbist_seq_state_e;

   localparam logic ENG_ROM = 1'b0;
   localparam logic ENG_RAM = 1'b1;

   localparam int unsigned DEF_SETTLE_CYCLES = 4;
   localparam int unsigned DEF_RST_CYCLES    = 8;

endpackage

// File: rtl/mbist_sync2.sv
// mbist_sync2: 2-flop synchronizer, async active-low reset to 0.
// Ports: clk, rst_n, d (async input), q (synchronized output).
module mbist_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/mbist_seq.sv
// mbist_seq: runs ROM then RAM BIST engines, reports sticky pass/timeout.
// Ports: start_i/sel_i/algo_mode_i in; busy/done/pass/timeout status out;
// testmode_o and per-engine en/async_resetn/algo pins to the BIST wrapper;
// engine DONE/GO in (async to clk). Watchdog built only when
// MBIST_SEQ_TIMEOUT_EN is defined; otherwise RUN waits for DONE forever.
module mbist_seq
   import mbist_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
   parameter int unsigned TIMEOUT_W     = 24,
   parameter logic [TIMEOUT_W-1:0] TIMEOUT_MAX = 24'hFF_FFFF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_i,
   input  logic [1:0] sel_i,
   input  logic [1:0] algo_mode_i,
   output logic       busy_o,
   output logic       done_o,
   output logic       rom_pass_o,
   output logic       ram_pass_o,
   output logic       timeout_o,
   output logic       testmode_o,
   output logic       rom_en_o,
   output logic       rom_async_resetn_o,
   input  logic       rom_done_i,
   input  logic       rom_go_i,
   output logic       ram_en_o,
   output logic       ram_async_resetn_o,
   output logic [1:0] ram_algo_mode_o,
   input  logic       ram_done_i,
   input  logic       ram_go_i
);

   localparam int unsigned CNT_MAX =
      (SETTLE_CYCLES > RST_CYCLES) ? SETTLE_CYCLES : RST_CYCLES;
   localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

   mbist_seq_state_e state;
   logic             cur_eng;
   logic [1:0]       sel_q;
   logic [CNT_W-1:0] cnt;
   logic             to_hit;

   logic rom_done_s, rom_go_s;
   logic ram_done_s, ram_go_s;
   logic done_s, go_s;

   mbist_sync2 u_sync_rom_done (
      .clk(clk), .rst_n(rst_n), .d(rom_done_i), .q(rom_done_s));
   mbist_sync2 u_sync_rom_go (
      .clk(clk), .rst_n(rst_n), .d(rom_go_i), .q(rom_go_s));
   mbist_sync2 u_sync_ram_done (
      .clk(clk), .rst_n(rst_n), .d(ram_done_i), .q(ram_done_s));
   mbist_sync2 u_sync_ram_go (
      .clk(clk), .rst_n(rst_n), .d(ram_go_i), .q(ram_go_s));

   assign done_s = (cur_eng == ENG_RAM) ? ram_done_s : rom_done_s;
   assign go_s   = (cur_eng == ENG_RAM) ? ram_go_s : rom_go_s;

`ifdef MBIST_SEQ_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] wdog;
`else
   logic unused_cfg;
   assign unused_cfg = ^TIMEOUT_MAX ^ (TIMEOUT_W == 0);
   assign to_hit     = 1'b0;
   assign timeout_o  = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= ST_IDLE;
         cur_eng            <= ENG_ROM;
         sel_q              <= 2'b00;
         cnt                <= '0;
         busy_o             <= 1'b0;
         done_o             <= 1'b0;
         rom_pass_o         <= 1'b0;
         ram_pass_o         <= 1'b0;
         testmode_o         <= 1'b0;
         rom_en_o           <= 1'b0;
         rom_async_resetn_o <= 1'b0;
         ram_en_o           <= 1'b0;
         ram_async_resetn_o <= 1'b0;
         ram_algo_mode_o    <= 2'b00;
`ifdef MBIST_SEQ_TIMEOUT_EN
         wdog               <= '0;
         to_hit             <= 1'b0;
         timeout_o          <= 1'b0;
`endif
      end else begin
         done_o <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               // Engines sit released but disabled between runs.
               rom_async_resetn_o <= 1'b1;
               ram_async_resetn_o <= 1'b1;
               if (start_i) begin
                  sel_q           <= sel_i;
                  ram_algo_mode_o <= algo_mode_i;
                  rom_pass_o      <= 1'b0;
                  ram_pass_o      <= 1'b0;
`ifdef MBIST_SEQ_TIMEOUT_EN
                  timeout_o       <= 1'b0;
`endif
                  busy_o          <= 1'b1;
                  cnt             <= '0;
                  if (sel_i == 2'b00) begin
                     state <= ST_FINISH;
                  end else begin
                     testmode_o <= 1'b1;
                     state      <= ST_ISOLATE;
                  end
               end
            end
            ST_ISOLATE: begin
               if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                  cnt   <= '0;
                  state <= ST_RST;
                  if (sel_q[0]) begin
                     cur_eng            <= ENG_ROM;
                     rom_async_resetn_o <= 1'b0;
                  end else begin
                     cur_eng            <= ENG_RAM;
                     ram_async_resetn_o <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_RST: begin
               if (cnt == CNT_W'(RST_CYCLES - 1)) begin
                  cnt   <= '0;
                  state <= ST_RUN;
                  if (cur_eng == ENG_ROM) begin
                     rom_async_resetn_o <= 1'b1;
                     rom_en_o           <= 1'b1;
                  end else begin
                     ram_async_resetn_o <= 1'b1;
                     ram_en_o           <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_RUN: begin
               // DONE is tested first so it wins a tie with the watchdog.
               if (done_s) begin
                  rom_en_o <= 1'b0;
                  ram_en_o <= 1'b0;
                  state    <= ST_CHECK;
`ifdef MBIST_SEQ_TIMEOUT_EN
                  wdog     <= '0;
               end else if (wdog == TIMEOUT_MAX) begin
                  timeout_o <= 1'b1;
                  to_hit    <= 1'b1;
                  if (cur_eng == ENG_ROM) rom_pass_o <= 1'b0;
                  else                    ram_pass_o <= 1'b0;
                  rom_en_o  <= 1'b0;
                  ram_en_o  <= 1'b0;
                  wdog      <= '0;
                  state     <= ST_CHECK;
               end else begin
                  wdog <= wdog + 1'b1;
`endif
               end
            end
            ST_CHECK: begin
               if (!to_hit) begin
                  if (cur_eng == ENG_ROM) rom_pass_o <= go_s;
                  else                    ram_pass_o <= go_s;
               end
`ifdef MBIST_SEQ_TIMEOUT_EN
               to_hit <= 1'b0;
`endif
               if (cur_eng == ENG_ROM && sel_q[1]) begin
                  cur_eng            <= ENG_RAM;
                  ram_async_resetn_o <= 1'b0;
                  cnt                <= '0;
                  state              <= ST_RST;
               end else begin
                  state <= ST_FINISH;
               end
            end
            ST_FINISH: begin
               testmode_o      <= 1'b0;
               done_o          <= 1'b1;
               busy_o          <= 1'b0;
               ram_algo_mode_o <= 2'b00;
               state           <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mbist_seq.sv
// tb_mbist_seq: scoreboard bench for mbist_seq with behavioural engines.
// Define MBIST_SEQ_TIMEOUT_EN to include the watchdog scenarios.
module tb_mbist_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start_i;
   logic [1:0] sel_i;
   logic [1:0] algo_mode_i;
   logic       busy_o, done_o, rom_pass_o, ram_pass_o, timeout_o;
   logic       testmode_o;
   logic       rom_en_o, rom_async_resetn_o;
   logic       ram_en_o, ram_async_resetn_o;
   logic [1:0] ram_algo_mode_o;
   logic       rom_done_i, rom_go_i, ram_done_i, ram_go_i;

   always #5 clk = ~clk;

   mbist_seq #(
      .SETTLE_CYCLES(4),
      .RST_CYCLES(8),
      .TIMEOUT_W(24),
      .TIMEOUT_MAX(24'd50)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .start_i(start_i), .sel_i(sel_i), .algo_mode_i(algo_mode_i),
      .busy_o(busy_o), .done_o(done_o),
      .rom_pass_o(rom_pass_o), .ram_pass_o(ram_pass_o),
      .timeout_o(timeout_o), .testmode_o(testmode_o),
      .rom_en_o(rom_en_o), .rom_async_resetn_o(rom_async_resetn_o),
      .rom_done_i(rom_done_i), .rom_go_i(rom_go_i),
      .ram_en_o(ram_en_o), .ram_async_resetn_o(ram_async_resetn_o),
      .ram_algo_mode_o(ram_algo_mode_o),
      .ram_done_i(ram_done_i), .ram_go_i(ram_go_i)
   );

   typedef struct {
      logic [1:0] sel;
      logic       rp;
      logic       ap;
      logic       to;
   } exp_t;

   exp_t sbq[$];
   int   vec = 0;
   int   errs = 0;
   int   cyc = 0;

   // Current plan: engine DONE delay in enabled cycles (0 = never), GO.
   int         p_rd, p_ad;
   logic       p_rg, p_ag;
   logic [1:0] run_sel = 2'b00;
   logic [1:0] run_algo = 2'b00;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   // An engine counts as timed out when its DONE would reach CHECK
   // later than 51 cycles after EN rose (DONE + 3 cycle latency).
   function automatic bit tmo(input int d);
`ifdef MBIST_SEQ_TIMEOUT_EN
      return (d == 0) || (d >= 50);
`else
      return d == 0;
`endif
   endfunction

   // Behavioural BIST engines.
   int rcnt, acnt;
   initial begin
      rom_done_i = 0; rom_go_i = 0; ram_done_i = 0; ram_go_i = 0;
      rcnt = 0; acnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n || !rom_async_resetn_o) begin
            rom_done_i = 0; rom_go_i = 0; rcnt = 0;
         end else if (rom_en_o) begin
            rcnt++;
            if (p_rd != 0 && rcnt == p_rd) begin
               rom_done_i = 1; rom_go_i = p_rg;
            end
         end
         if (!rst_n || !ram_async_resetn_o) begin
            ram_done_i = 0; ram_go_i = 0; acnt = 0;
         end else if (ram_en_o) begin
            acnt++;
            if (p_ad != 0 && acnt == p_ad) begin
               ram_done_i = 1; ram_go_i = p_ag;
            end
         end
      end
   end

   // Monitor: pops the scoreboard on done_o and checks pin timing.
   bit         pend = 0, in_run = 0, rom_ran = 0;
   int         s_cyc = 0, nfall = 0, ex;
   int         rf[2], er[2], dc[2];
   bit         dseen[2];
   logic [1:0] en, rs, dn;
   logic [1:0] pen = 0, prst = 0, pdone = 0;
   exp_t       me;

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         en = {ram_en_o, rom_en_o};
         rs = {ram_async_resetn_o, rom_async_resetn_o};
         dn = {ram_done_i, rom_done_i};
         if (!rst_n) begin
            pend = 0;
            in_run = 0;
         end else begin
            if (pend) begin
               in_run = 1;
               pend = 0;
            end
            if (done_o) begin
               in_run = 0;
               if (sbq.size() == 0) begin
                  chk("extra_done", 1, 0);
               end else begin
                  me = sbq.pop_front();
                  chk("rom_pass", rom_pass_o, me.rp);
                  chk("ram_pass", ram_pass_o, me.ap);
                  chk("timeout", timeout_o, me.to);
                  if (me.sel == 2'b00)
                     chk("empty_sel_lat", cyc - s_cyc, 2);
               end
            end
            chk("busy", busy_o, in_run);
            chk("testmode", testmode_o, in_run && run_sel != 0);
            chk("algo", ram_algo_mode_o, in_run ? run_algo : 2'b00);
            for (int i = 0; i < 2; i++) begin
               if (in_run && prst[i] && !rs[i]) begin
                  if (nfall == 0) chk("settle", cyc - s_cyc, 5);
                  nfall++;
                  rf[i] = cyc;
               end
               if (in_run && !prst[i] && rs[i])
                  chk("rst_len", cyc - rf[i], 8);
               if (!pen[i] && en[i]) begin
                  chk("en_selected", run_sel[i], 1);
                  if (i == 1 && run_sel[0]) chk("rom_first", rom_ran, 1);
                  er[i] = cyc;
                  dseen[i] = 0;
               end
               if (en[i] && dn[i] && !pdone[i] && !dseen[i]) begin
                  dseen[i] = 1;
                  dc[i] = cyc;
               end
               if (pen[i] && !en[i]) begin
                  ex = dseen[i] ? dc[i] + 3 : cyc + 1000;
`ifdef MBIST_SEQ_TIMEOUT_EN
                  if (er[i] + 51 < ex) ex = er[i] + 51;
`endif
                  chk(i == 0 ? "rom_en_fall" : "ram_en_fall", cyc, ex);
                  if (i == 0) rom_ran = 1;
               end
            end
            if (start_i && !in_run && !pend) begin
               pend = 1;
               s_cyc = cyc;
               nfall = 0;
               rom_ran = 0;
            end
         end
         pen = en;
         prst = rs;
         pdone = dn;
      end
   end

   task automatic rst_chk(input string p);
      chk({p, "busy"}, busy_o, 0);
      chk({p, "done"}, done_o, 0);
      chk({p, "rom_pass"}, rom_pass_o, 0);
      chk({p, "ram_pass"}, ram_pass_o, 0);
      chk({p, "timeout"}, timeout_o, 0);
      chk({p, "testmode"}, testmode_o, 0);
      chk({p, "rom_en"}, rom_en_o, 0);
      chk({p, "rom_rstn"}, rom_async_resetn_o, 0);
      chk({p, "ram_en"}, ram_en_o, 0);
      chk({p, "ram_rstn"}, ram_async_resetn_o, 0);
      chk({p, "algo"}, ram_algo_mode_o, 0);
   endtask

   task automatic wait_en();
      for (int i = 0; i < 400 && !(rom_en_o || ram_en_o); i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run(input logic [1:0] s, input logic [1:0] a,
                      input int rd, input logic rg,
                      input int ad, input logic ag, input bit extra);
      exp_t e;
      bit   seen;
      p_rd = rd; p_rg = rg; p_ad = ad; p_ag = ag;
      run_sel = s;
      run_algo = a;
      e.sel = s;
      e.to = (s[0] && tmo(rd)) || (s[1] && tmo(ad));
      e.rp = s[0] && !tmo(rd) && rg;
      e.ap = s[1] && !tmo(ad) && ag;
      sbq.push_back(e);
      @(posedge clk); #1;
      start_i = 1; sel_i = s; algo_mode_i = a;
      @(posedge clk); #1;
      start_i = 0; sel_i = 2'($urandom); algo_mode_i = 2'($urandom);
      if (extra && s != 0) begin
         wait_en();
         start_i = 1; sel_i = 2'($urandom);
         @(posedge clk); #1;
         start_i = 0;
      end
      seen = 0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         @(negedge clk);
         seen = done_o;
      end
      if (!seen) begin
         chk("done_wait", 0, 1);
         sbq.delete();
      end
      repeat (3) @(posedge clk);
   endtask

   int rd, ad;

   initial begin
      rst_n = 0; start_i = 0; sel_i = 0; algo_mode_i = 0;
      p_rd = 0; p_ad = 0; p_rg = 0; p_ag = 0;
      repeat (3) @(posedge clk);
      #2;
      rst_chk("rst_");
      #1 rst_n = 1;
      @(posedge clk); #1;
      chk("idle_rom_rstn", rom_async_resetn_o, 1);
      chk("idle_ram_rstn", ram_async_resetn_o, 1);
      chk("idle_rom_en", rom_en_o, 0);

      run(2'b01, 2'b00, 100, 1, 0, 0, 0);
      run(2'b11, 2'b10, 20, 1, 30, 0, 0);
      run(2'b10, 2'b01, 5, 0, 25, 1, 1);
      run(2'b00, 2'b11, 10, 1, 10, 1, 0);
`ifdef MBIST_SEQ_TIMEOUT_EN
      run(2'b11, 2'b00, 0, 1, 10, 1, 0);
      run(2'b01, 2'b00, 49, 1, 0, 0, 0);
      run(2'b01, 2'b00, 50, 1, 0, 0, 0);
`endif

      // Reset while the ROM engine is running.
      p_rd = 30; p_rg = 1; p_ad = 30; p_ag = 1;
      run_sel = 2'b11;
      run_algo = 2'b01;
      @(posedge clk); #1;
      start_i = 1; sel_i = 2'b11; algo_mode_i = 2'b01;
      @(posedge clk); #1;
      start_i = 0;
      wait_en();
      repeat (10) @(posedge clk);
      #3 rst_n = 0;
      #1 rst_chk("mid_");
      repeat (3) @(posedge clk);
      #3 rst_n = 1;
      repeat (2) @(posedge clk);
      run(2'b11, 2'b01, 12, 1, 15, 1, 0);

      for (int n = 0; n < 20; n++) begin
         rd = $urandom_range(1, 45);
         ad = $urandom_range(1, 45);
`ifdef MBIST_SEQ_TIMEOUT_EN
         if ($urandom_range(0, 4) == 0) rd = $urandom_range(0, 1) * 60;
         if ($urandom_range(0, 4) == 0) ad = $urandom_range(0, 1) * 60;
`endif
         run(2'($urandom_range(0, 3)), 2'($urandom), rd,
             1'($urandom), ad, 1'($urandom), $urandom_range(0, 3) == 0);
      end

      repeat (5) @(posedge clk);
      chk("sb_empty", sbq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
